dma_copy_engine: RTL and testbench

- DMA initiator that drives the read/write command, data and completion streams of a DMA or HBM memory responder.
- Accepts one copy request at a time (source address, destination address, byte length) and splits it into bursts of at most MAX_BURST_BYTES.
- For each burst it issues one read command and one write command, then forwards read beats directly onto the write data stream.
- Reports completion only after every write burst has been acknowledged on the back channel.

---
 rtl/dma_copy_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_dma_copy_engine.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_engine.sv
// DMA copy engine: splits one copy request into bursts of at most
// MAX_BURST_BYTES, issues a read and a write command per burst, streams the
// read beats straight onto the write data channel, and signals completion
// once every issued write burst has been acknowledged.
module dma_copy_engine #(
    parameter int width           = 512,
    parameter int MAX_BURST_BYTES = 4096,
    parameter int ACK_CNT_W       = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [63:0]            req_src_addr,
    input  logic [63:0]            req_dst_addr,
    input  logic [31:0]            req_length,
    output logic                   read_cmd_valid,
    input  logic                   read_cmd_ready,
    output logic [63:0]            read_cmd_address,
    output logic [31:0]            read_cmd_length,
    output logic                   write_cmd_valid,
    input  logic                   write_cmd_ready,
    output logic [63:0]            write_cmd_address,
    output logic [31:0]            write_cmd_length,
    input  logic                   read_data_valid,
    output logic                   read_data_ready,
    input  logic [width-1:0]       read_data_data,
    input  logic [width/8-1:0]     read_data_keep,
    input  logic                   read_data_last,
    output logic                   write_data_valid,
    input  logic                   write_data_ready,
    output logic [width-1:0]       write_data_data,
    output logic [width/8-1:0]     write_data_keep,
    output logic                   write_data_last,
    input  logic                   back_valid,
    output logic                   back_ready,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic                   busy,
    output logic                   err_last
);

    localparam int BEAT_BYTES = width / 8;
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam logic [31:0] MAX_BURST = 32'(MAX_BURST_BYTES);
    localparam logic [31:0] LEN_MASK  = ~(32'(BEAT_BYTES) - 32'd1);
    localparam logic [ACK_CNT_W-1:0] CNT_ONE  = ACK_CNT_W'(1);
    localparam logic [ACK_CNT_W-1:0] CNT_ZERO = ACK_CNT_W'(0);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_NEXT     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]           state;
    logic [63:0]          src;
    logic [63:0]          dst;
    logic [31:0]          remaining;
    logic [31:0]          beat_cnt;
    logic [ACK_CNT_W-1:0] issued;
    logic [ACK_CNT_W-1:0] ack_cnt;
    logic                 rd_sent;
    logic                 wr_sent;
    logic                 err_flag;

    logic [31:0] chunk;
    logic [31:0] chunk_beats;
    logic        in_cmd;
    logic        in_data;
    logic        last_beat;
    logic        rd_hs;
    logic        wr_hs;
    logic        cmds_done;
    logic        beat_xfer;
    logic        ack_xfer;
    logic        req_xfer;
    logic        unused_keep;

    // Byte enables on the read side carry no information for a full-beat copy.
    assign unused_keep = ^read_data_keep;

    // Size of the current burst: whatever is left, capped at one max burst.
    always_comb begin
        if (remaining > MAX_BURST) begin
            chunk = MAX_BURST;
        end else begin
            chunk = remaining;
        end
        chunk_beats = chunk >> BEAT_SHIFT;
    end

    assign in_cmd    = (state == S_CMD);
    assign in_data   = (state == S_DATA);
    assign last_beat = (beat_cnt == (chunk_beats - 32'd1));

    assign read_cmd_valid    = in_cmd & ~rd_sent;
    assign write_cmd_valid   = in_cmd & ~wr_sent;
    assign read_cmd_address  = src;
    assign write_cmd_address = dst;
    assign read_cmd_length   = chunk;
    assign write_cmd_length  = chunk;

    assign rd_hs     = read_cmd_valid & read_cmd_ready;
    assign wr_hs     = write_cmd_valid & write_cmd_ready;
    assign cmds_done = in_cmd & (rd_sent | rd_hs) & (wr_sent | wr_hs);
    assign beat_xfer = in_data & read_data_valid & write_data_ready;

    assign back_ready = ~reset;
    assign ack_xfer   = back_valid & back_ready;
    assign req_ready  = (state == S_IDLE) & ~reset;
    assign req_xfer   = req_valid & req_ready;
    assign done_valid = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign err_last   = err_flag;

    // Zero-latency pass-through of read beats onto the write stream during DATA.
    always_comb begin
        write_data_valid = 1'b0;
        read_data_ready  = 1'b0;
        write_data_data  = {width{1'b0}};
        write_data_keep  = {(width/8){1'b0}};
        write_data_last  = 1'b0;
        if (in_data) begin
            write_data_valid = read_data_valid;
            read_data_ready  = write_data_ready;
            write_data_data  = read_data_data;
            write_data_keep  = {(width/8){1'b1}};
            write_data_last  = last_beat;
        end else begin
            write_data_valid = 1'b0;
            read_data_ready  = 1'b0;
        end
    end

    // Completion counter: a new request restarts it, every accepted ack bumps it.
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_cnt <= CNT_ZERO;
        end else if (req_xfer) begin
            ack_cnt <= CNT_ZERO;
        end else if (ack_xfer) begin
            ack_cnt <= ack_cnt + CNT_ONE;
        end
    end

    // Sticky flag for a read burst whose last marker disagrees with the beat count.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (beat_xfer && (read_data_last != last_beat)) begin
            err_flag <= 1'b1;
        end
    end

    // Main sequencer: request capture, command issue, beat counting, burst advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            src       <= 64'd0;
            dst       <= 64'd0;
            remaining <= 32'd0;
            beat_cnt  <= 32'd0;
            issued    <= CNT_ZERO;
            rd_sent   <= 1'b0;
            wr_sent   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        src       <= req_src_addr;
                        dst       <= req_dst_addr;
                        remaining <= req_length & LEN_MASK;
                        beat_cnt  <= 32'd0;
                        issued    <= CNT_ZERO;
                        rd_sent   <= 1'b0;
                        wr_sent   <= 1'b0;
                        if ((req_length & LEN_MASK) == 32'd0) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_CMD;
                        end
                    end
                end
                S_CMD: begin
                    if (cmds_done) begin
                        issued  <= issued + CNT_ONE;
                        rd_sent <= 1'b0;
                        wr_sent <= 1'b0;
                        state   <= S_DATA;
                    end else begin
                        if (rd_hs) begin
                            rd_sent <= 1'b1;
                        end
                        if (wr_hs) begin
                            wr_sent <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (beat_xfer) begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (last_beat) begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    src       <= src + {32'd0, chunk};
                    dst       <= dst + {32'd0, chunk};
                    remaining <= remaining - chunk;
                    beat_cnt  <= 32'd0;
                    if (remaining != chunk) begin
                        state <= S_CMD;
                    end else begin
                        state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (ack_cnt == issued) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (done_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine: randomized command/data/ack
// responders plus an offset-based reference of the expected bursts and beats.
module tb_dma_copy_engine;

    localparam int W    = 512;
    localparam int BB   = W / 8;
    localparam int MAXB = 4096;
    localparam logic [BB-1:0] ALL_KEEP = {BB{1'b1}};

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_src_addr;
    logic [63:0]   req_dst_addr;
    logic [31:0]   req_length;
    logic          read_cmd_valid;
    logic          read_cmd_ready;
    logic [63:0]   read_cmd_address;
    logic [31:0]   read_cmd_length;
    logic          write_cmd_valid;
    logic          write_cmd_ready;
    logic [63:0]   write_cmd_address;
    logic [31:0]   write_cmd_length;
    logic          read_data_valid;
    logic          read_data_ready;
    logic [W-1:0]  read_data_data;
    logic [BB-1:0] read_data_keep;
    logic          read_data_last;
    logic          write_data_valid;
    logic          write_data_ready;
    logic [W-1:0]  write_data_data;
    logic [BB-1:0] write_data_keep;
    logic          write_data_last;
    logic          back_valid;
    logic          back_ready;
    logic          done_valid;
    logic          done_ready;
    logic          busy;
    logic          err_last;

    dma_copy_engine #(.width(W), .MAX_BURST_BYTES(MAXB), .ACK_CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src_addr(req_src_addr), .req_dst_addr(req_dst_addr), .req_length(req_length),
        .read_cmd_valid(read_cmd_valid), .read_cmd_ready(read_cmd_ready),
        .read_cmd_address(read_cmd_address), .read_cmd_length(read_cmd_length),
        .write_cmd_valid(write_cmd_valid), .write_cmd_ready(write_cmd_ready),
        .write_cmd_address(write_cmd_address), .write_cmd_length(write_cmd_length),
        .read_data_valid(read_data_valid), .read_data_ready(read_data_ready),
        .read_data_data(read_data_data), .read_data_keep(read_data_keep),
        .read_data_last(read_data_last),
        .write_data_valid(write_data_valid), .write_data_ready(write_data_ready),
        .write_data_data(write_data_data), .write_data_keep(write_data_keep),
        .write_data_last(write_data_last),
        .back_valid(back_valid), .back_ready(back_ready),
        .done_valid(done_valid), .done_ready(done_ready),
        .busy(busy), .err_last(err_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] salt = 64'd0;

    // responder / observation state
    logic [63:0]  rq_addr[$];
    int           rq_len[$];
    int           wq_beats[$];
    logic [63:0]  obs_rd_addr[$];
    int           obs_rd_len[$];
    logic [63:0]  obs_wr_addr[$];
    int           obs_wr_len[$];
    logic [W-1:0] obs_data[$];
    bit           obs_last[$];
    logic [63:0]  cur_rd_addr;
    int  cur_rd_left, cur_wr_left, n_rd_cmd, n_wr_cmd, bursts_done;
    int  ack_pending, acks_given, beat_no, hs_cyc, done_cyc, acks_at_done;
    int  mirror_bad, rdy_in_done_bad, script_idx;
    bit  rd_offer, back_taken, req_taken, done_seen, done_taken;
    int  early_last_beat = -1;
    bit  wr_script = 1'b0;
    bit  done_hold = 1'b0;
    bit  pat4 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // reference model
    logic [63:0]  exp_rd_addr[$];
    logic [63:0]  exp_wr_addr[$];
    int           exp_len[$];
    logic [W-1:0] exp_data[$];
    bit           exp_last[$];

    function automatic logic [W-1:0] pat(input logic [63:0] a);
        return {8{a ^ salt}};
    endfunction

    task automatic clear_model();
        rq_addr.delete(); rq_len.delete(); wq_beats.delete();
        obs_rd_addr.delete(); obs_rd_len.delete(); obs_wr_addr.delete(); obs_wr_len.delete();
        obs_data.delete(); obs_last.delete();
        cur_rd_left = 0; cur_wr_left = 0; n_rd_cmd = 0; n_wr_cmd = 0; bursts_done = 0;
        ack_pending = 0; acks_given = 0; beat_no = 0; hs_cyc = -1; done_cyc = -1;
        acks_at_done = -1; mirror_bad = 0; rdy_in_done_bad = 0; script_idx = 0;
        rd_offer = 0; back_taken = 0; req_taken = 0; done_seen = 0; done_taken = 0;
        read_data_valid = 1'b0; read_data_last = 1'b0; back_valid = 1'b0; req_valid = 1'b0;
    endtask

    // Expected bursts and beats, derived from byte offsets into the copy.
    task automatic build_model(input logic [63:0] s, input logic [63:0] d, input logic [31:0] len);
        int total;
        int c;
        total = (int'(len) / BB) * BB;
        exp_rd_addr.delete(); exp_wr_addr.delete(); exp_len.delete();
        exp_data.delete(); exp_last.delete();
        for (int off = 0; off < total; off += MAXB) begin
            c = (total - off < MAXB) ? (total - off) : MAXB;
            exp_rd_addr.push_back(s + 64'(off));
            exp_wr_addr.push_back(d + 64'(off));
            exp_len.push_back(c);
            for (int b = 0; b < c / BB; b++) begin
                exp_data.push_back(pat(s + 64'(off + b * BB)));
                exp_last.push_back(b == (c / BB) - 1);
            end
        end
    endtask

    function automatic int cmd_diffs();
        int n = 0;
        if (obs_rd_addr.size() != exp_rd_addr.size()) n++;
        if (obs_wr_addr.size() != exp_wr_addr.size()) n++;
        for (int i = 0; i < exp_len.size(); i++) begin
            if (i < obs_rd_addr.size())
                if (obs_rd_addr[i] !== exp_rd_addr[i] || obs_rd_len[i] != exp_len[i]) n++;
            if (i < obs_wr_addr.size())
                if (obs_wr_addr[i] !== exp_wr_addr[i] || obs_wr_len[i] != exp_len[i]) n++;
        end
        return n;
    endfunction

    function automatic int beat_diffs();
        int n = 0;
        if (obs_data.size() != exp_data.size()) n++;
        for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++)
            if (obs_data[i] !== exp_data[i] || obs_last[i] != exp_last[i]) n++;
        return n;
    endfunction

    task automatic drive_inputs();
        if (req_taken) req_valid = 1'b0;
        read_cmd_ready  = ($urandom_range(0, 3) != 0);
        write_cmd_ready = ($urandom_range(0, 3) != 0);
        if (!rd_offer) begin
            if (cur_rd_left == 0 && rq_addr.size() > 0) begin
                cur_rd_addr = rq_addr.pop_front();
                cur_rd_left = rq_len.pop_front() / BB;
            end
            if (cur_rd_left > 0 && $urandom_range(0, 3) != 0) begin
                read_data_valid = 1'b1;
                read_data_data  = pat(cur_rd_addr);
                read_data_keep  = {$urandom(), $urandom()};
                read_data_last  = (cur_rd_left == 1) ^ (beat_no == early_last_beat);
                rd_offer = 1'b1;
            end else begin
                read_data_valid = 1'b0;
                read_data_last  = 1'b0;
            end
        end
        if (wr_script) begin
            write_data_ready = pat4[script_idx % 4];
            script_idx++;
        end else begin
            write_data_ready = ($urandom_range(0, 3) != 0);
        end
        if (back_taken) begin
            back_valid = 1'b0;
            back_taken = 1'b0;
        end
        if (!back_valid && ack_pending > 0 && $urandom_range(0, 3) == 0) back_valid = 1'b1;
        done_ready = done_hold ? 1'b0 : ($urandom_range(0, 1) == 1);
    endtask

    task automatic observe();
        bit in_data;
        cyc++;
        in_data = (n_rd_cmd > bursts_done) && (n_wr_cmd > bursts_done);
        if (read_data_ready !== (in_data && write_data_ready) ||
            write_data_valid !== (in_data && read_data_valid)) mirror_bad++;
        if (in_data && write_data_valid &&
            (write_data_data !== read_data_data || write_data_keep !== ALL_KEEP)) mirror_bad++;
        if (req_valid && req_ready) begin
            req_taken = 1'b1;
            hs_cyc = cyc;
        end
        if (read_cmd_valid && read_cmd_ready) begin
            obs_rd_addr.push_back(read_cmd_address);
            obs_rd_len.push_back(int'(read_cmd_length));
            rq_addr.push_back(read_cmd_address);
            rq_len.push_back(int'(read_cmd_length));
            n_rd_cmd++;
        end
        if (write_cmd_valid && write_cmd_ready) begin
            obs_wr_addr.push_back(write_cmd_address);
            obs_wr_len.push_back(int'(write_cmd_length));
            wq_beats.push_back(int'(write_cmd_length) / BB);
            n_wr_cmd++;
        end
        if (read_data_valid && read_data_ready) begin
            obs_data.push_back(write_data_data);
            obs_last.push_back(write_data_last);
            rd_offer = 1'b0;
            cur_rd_addr += 64'(BB);
            cur_rd_left--;
            beat_no++;
            if (cur_wr_left == 0 && wq_beats.size() > 0) cur_wr_left = wq_beats.pop_front();
            if (cur_wr_left > 0) begin
                cur_wr_left--;
                if (cur_wr_left == 0) begin
                    ack_pending++;
                    bursts_done++;
                end
            end
        end
        if (back_valid && back_ready) begin
            ack_pending--;
            acks_given++;
            back_taken = 1'b1;
        end
        if (done_valid && !done_seen) begin
            done_seen = 1'b1;
            done_cyc = cyc;
            acks_at_done = acks_given;
        end
        if (done_valid && req_ready) rdy_in_done_bad++;
        if (done_valid && done_ready) done_taken = 1'b1;
    endtask

    task automatic step();
        drive_inputs();
        #1;
        observe();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic start_copy(input logic [63:0] s, input logic [63:0] d, input logic [31:0] len);
        clear_model();
        build_model(s, d, len);
        req_src_addr = s;
        req_dst_addr = d;
        req_length   = len;
        req_valid    = 1'b1;
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_taken) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({req_ready, back_ready, busy, done_valid, read_cmd_valid, write_cmd_valid,
             read_data_ready, write_data_valid, write_data_last, err_last} !== 10'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0", {req_ready, back_ready, busy, done_valid,
                     read_cmd_valid, write_cmd_valid, read_data_ready, write_data_valid,
                     write_data_last, err_last});
        end
        checks++;
        if ({read_cmd_address, write_cmd_address, read_cmd_length, write_cmd_length} !== 192'd0) begin
            errors++;
            $display("FAIL reset_cmd_fields: got rd %h wr %h expected 0", read_cmd_address, write_cmd_address);
        end
        reset = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if ({req_ready, back_ready, busy} !== 3'b110) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 110", {req_ready, back_ready, busy});
        end
    endtask

    task automatic test_single_burst();
        bit ok;
        salt = 64'd0;
        start_copy(64'h0, 64'h10000, 32'd256);
        run_until_done(2000, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL single_done: got %0d expected 1", ok); end
        checks++;
        if (cmd_diffs() !== 0) begin errors++; $display("FAIL single_cmds: got %0d diffs expected 0", cmd_diffs()); end
        checks++;
        if (beat_diffs() !== 0 || obs_data.size() != 4) begin
            errors++; $display("FAIL single_beats: got %0d beats %0d diffs expected 4 beats 0 diffs", obs_data.size(), beat_diffs());
        end
        checks++;
        if (acks_at_done !== 1) begin errors++; $display("FAIL single_acks: got %0d expected 1", acks_at_done); end
    endtask

    task automatic test_multi_burst();
        bit ok;
        salt = 64'h1234_5678_9abc_def0;
        start_copy(64'h0, 64'h20_0000, 32'd10240);
        run_until_done(5000, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL multi_done: got %0d expected 1", ok); end
        checks++;
        if (cmd_diffs() !== 0 || obs_rd_addr.size() != 3) begin
            errors++; $display("FAIL multi_cmds: got %0d cmds %0d diffs expected 3 cmds 0 diffs", obs_rd_addr.size(), cmd_diffs());
        end
        checks++;
        if (beat_diffs() !== 0 || obs_data.size() != 160) begin
            errors++; $display("FAIL multi_beats: got %0d beats %0d diffs expected 160 beats 0 diffs", obs_data.size(), beat_diffs());
        end
        checks++;
        if (acks_at_done !== 3) begin errors++; $display("FAIL multi_acks_before_done: got %0d expected 3", acks_at_done); end
    endtask

    task automatic test_ready_toggle();
        bit ok;
        salt = 64'h0bad_cafe_0000_0001;
        wr_script = 1'b1;
        start_copy(64'h4000, 64'h8000, 32'd512);
        run_until_done(2000, ok);
        wr_script = 1'b0;
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL toggle_done: got %0d expected 1", ok); end
        checks++;
        if (mirror_bad !== 0) begin errors++; $display("FAIL toggle_mirror: got %0d bad cycles expected 0", mirror_bad); end
        checks++;
        if (beat_diffs() !== 0 || obs_data.size() != 8) begin
            errors++; $display("FAIL toggle_beats: got %0d beats %0d diffs expected 8 beats 0 diffs", obs_data.size(), beat_diffs());
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        logic [31:0] lens [2];
        lens[0] = 32'd0;
        lens[1] = 32'd63;
        for (int k = 0; k < 2; k++) begin
            start_copy(64'h100, 64'h200, lens[k]);
            run_until_done(100, ok);
            checks++;
            if (ok !== 1'b1 || obs_rd_addr.size() != 0 || obs_wr_addr.size() != 0) begin
                errors++; $display("FAIL zero_len_%0d: got done %0d rd %0d wr %0d expected done 1 no cmds",
                                   lens[k], ok, obs_rd_addr.size(), obs_wr_addr.size());
            end
            checks++;
            if (!(done_cyc - hs_cyc >= 1 && done_cyc - hs_cyc <= 2)) begin
                errors++; $display("FAIL zero_len_latency_%0d: got %0d cycles expected 1..2", lens[k], done_cyc - hs_cyc);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [63:0] s;
        logic [63:0] d;
        logic [31:0] len;
        for (int it = 0; it < 6; it++) begin
            salt = {$urandom(), $urandom()};
            s = {$urandom(), $urandom()};
            d = {$urandom(), $urandom()};
            len = 32'($urandom_range(0, 9000));
            if (it == 0) begin
                s = 64'hFFFF_FFFF_FFFF_F800;
                len = 32'd6000;
            end
            start_copy(s, d, len);
            run_until_done(6000, ok);
            checks++;
            if (ok !== 1'b1 || cmd_diffs() !== 0 || beat_diffs() !== 0) begin
                errors++; $display("FAIL random_%0d: got done %0d cmd_diffs %0d beat_diffs %0d expected 1 0 0 (len %0d)",
                                   it, ok, cmd_diffs(), beat_diffs(), len);
            end
            checks++;
            if (acks_at_done !== exp_len.size() || mirror_bad !== 0 || err_last !== 1'b0) begin
                errors++; $display("FAIL random_acks_%0d: got acks %0d mirror %0d err %0d expected %0d 0 0",
                                   it, acks_at_done, mirror_bad, err_last, exp_len.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        salt = 64'h5555_0000_aaaa_0000;
        start_copy(64'h1_0000, 64'h2_0000, 32'd4096);
        for (int i = 0; i < 3000 && beat_no < 10; i++) step();
        checks++;
        if (beat_no !== 10) begin errors++; $display("FAIL reset_mid_reach: got %0d beats expected 10", beat_no); end
        reset = 1'b1;
        clear_model();
        @(posedge clock);
        @(negedge clock);
        #1;
        checks++;
        if ({req_ready, back_ready, busy, done_valid, read_cmd_valid, write_cmd_valid,
             read_data_ready, write_data_valid, write_data_last, err_last} !== 10'd0 ||
            write_data_data !== {W{1'b0}} || write_data_keep !== {BB{1'b0}}) begin
            errors++; $display("FAIL reset_mid_outputs: got %b expected 0", {req_ready, back_ready, busy, done_valid,
                               read_cmd_valid, write_cmd_valid, read_data_ready, write_data_valid,
                               write_data_last, err_last});
        end
        reset = 1'b0;
        @(negedge clock);
        start_copy(64'h3_0000, 64'h4_0000, 32'd128);
        run_until_done(2000, ok);
        checks++;
        if (ok !== 1'b1 || cmd_diffs() !== 0 || beat_diffs() !== 0 || acks_at_done !== 1) begin
            errors++; $display("FAIL reset_mid_recover: got done %0d cmd %0d beat %0d acks %0d expected 1 0 0 1",
                               ok, cmd_diffs(), beat_diffs(), acks_at_done);
        end
    endtask

    task automatic test_done_hold();
        bit ok;
        int held_bad = 0;
        done_hold = 1'b1;
        start_copy(64'h500, 64'h900, 32'd256);
        for (int i = 0; i < 2000 && !done_seen; i++) step();
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_valid !== 1'b1 || req_ready !== 1'b0) held_bad++;
        end
        checks++;
        if (held_bad !== 0 || rdy_in_done_bad !== 0 || done_seen !== 1'b1) begin
            errors++; $display("FAIL done_hold: got %0d bad cycles, ready_in_done %0d, seen %0d expected 0 0 1",
                               held_bad, rdy_in_done_bad, done_seen);
        end
        done_hold = 1'b0;
        run_until_done(100, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL done_release: got %0d expected 1", ok); end
    endtask

    task automatic test_err_last();
        bit ok;
        checks++;
        if (err_last !== 1'b0) begin errors++; $display("FAIL err_last_clear: got %0d expected 0", err_last); end
        early_last_beat = 2;
        start_copy(64'h7000, 64'hF000, 32'd512);
        run_until_done(2000, ok);
        early_last_beat = -1;
        checks++;
        if (ok !== 1'b1 || err_last !== 1'b1 || beat_diffs() !== 0) begin
            errors++; $display("FAIL err_last_set: got done %0d err %0d beat_diffs %0d expected 1 1 0", ok, err_last, beat_diffs());
        end
        start_copy(64'h7000, 64'hF000, 32'd256);
        run_until_done(2000, ok);
        checks++;
        if (ok !== 1'b1 || err_last !== 1'b1) begin
            errors++; $display("FAIL err_last_sticky: got done %0d err %0d expected 1 1", ok, err_last);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_src_addr = 64'd0; req_dst_addr = 64'd0; req_length = 32'd0;
        read_cmd_ready = 1'b0; write_cmd_ready = 1'b0;
        read_data_valid = 1'b0; read_data_data = {W{1'b0}}; read_data_keep = {BB{1'b0}}; read_data_last = 1'b0;
        write_data_ready = 1'b0; back_valid = 1'b0; done_ready = 1'b0;
        clear_model();
        @(negedge clock);
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_ready_toggle();
        test_zero_len();
        test_random();
        test_reset_mid();
        test_done_hold();
        test_err_last();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
